divider_32bit: RTL
==================

DIVIDER_32BIT -- requirements
Module: divider_32bit

Interface
REQ-001 SHALL have no parameters; width is fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request pulse; sampled only while busy=0.
REQ-005 is_signed  input  1  1 = signed operation (RISC-V DIV/REM), 0 = unsigned (DIVU/REMU).
REQ-006 a  input  32  dividend; captured on the accepting edge.
REQ-007 b  input  32  divisor; captured on the accepting edge.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse marking the result as valid.
REQ-010 quotient  output  32  registered quotient.
REQ-011 remainder  output  32  registered remainder.

Function
REQ-012 SHALL be an FSM with states IDLE, CALC and DONE; the reset state SHALL be IDLE.
REQ-013 Accept: start=1 and busy=0 at edge N SHALL capture a, b and is_signed, set busy=1, and clear the 6-bit iteration counter.
REQ-014 start while busy=1 SHALL be ignored; operands SHALL not change mid-operation.
REQ-015 Normal path: edge N goes to CALC; each edge N+1..N+32 SHALL perform one restoring step: shift the remainder left with the next dividend MSB, trial-subtract the divisor magnitude over 33 bits, keep the result when it is non-negative, and shift the quotient bit in.
REQ-016 At edge N+33, quotient and remainder SHALL be registered with sign correction, done SHALL be set to 1, busy SHALL be cleared to 0, and the FSM SHALL enter DONE; fixed latency is 33 cycles.
REQ-017 Signed sign correction: operate on magnitudes; negate the quotient when the operand signs differ; the remainder SHALL take the sign of the dividend.
REQ-018 Divide by zero (b=0), signed or unsigned, SHALL take a fast path: at edge N+1, quotient=32'hFFFF_FFFF, remainder=a, and done=1.
REQ-019 Signed overflow (a=32'h8000_0000, b=32'hFFFF_FFFF, is_signed=1) SHALL take a fast path: at edge N+1, quotient=32'h8000_0000, remainder=0, and done=1.
REQ-020 done SHALL be high for exactly one cycle; DONE SHALL return to IDLE on the next edge.
REQ-021 Because busy=0 in the DONE cycle, start in that cycle SHALL be accepted (back-to-back operation).
REQ-022 quotient and remainder SHALL hold their values until the next done pulse, and SHALL not change during CALC.
REQ-023 The 33-bit trial subtraction SHALL use the team's ripple-carry adder chain (inverted divisor, c_in=1); the borrow is the inverted carry out.
REQ-024 Unsigned operands SHALL never be sign-extended; a with bit 31 set and is_signed=0 SHALL be treated as a positive value.

Reset
REQ-025 rst_n=0 SHALL immediately, without a clock, force state=IDLE, busy=0, done=0, quotient=0, remainder=0 and counter=0.
REQ-026 Reset during CALC or DONE SHALL abort the operation; no done pulse SHALL follow.
REQ-027 The first start after rst_n deasserts SHALL be accepted normally.

Verification
REQ-028 Unsigned 100/7 -> done at N+33, quotient=14, remainder=2, busy high for cycles N+1..N+33.
REQ-029 Signed -7/2 (32'hFFFF_FFF9, 2) -> quotient=32'hFFFF_FFFD (-3), remainder=32'hFFFF_FFFF (-1); the same operands with is_signed=0 -> quotient=32'h7FFF_FFFC, remainder=1.
REQ-030 Divide by zero with a=32'h1234_5678, b=0 -> done at N+1, quotient=32'hFFFF_FFFF, remainder=32'h1234_5678.
REQ-031 Signed overflow 32'h8000_0000 / 32'hFFFF_FFFF -> done at N+1, quotient=32'h8000_0000, remainder=0.
REQ-032 start pulsed at N+5 during CALC -> ignored, first result unaffected; start in the DONE cycle -> second operation completes 33 cycles later.
REQ-033 rst_n low at N+10 -> all outputs 0 asynchronously; no done in the following 40 cycles without a new start.

Source files
------------

// File: rtl/divider_32bit.sv
// 32-bit restoring divider, signed (DIV/REM) and unsigned (DIVU/REMU).
// Fixed 33-cycle latency on the normal path; divide-by-zero and signed
// overflow resolve one cycle after acceptance.
module divider_32bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q;
    logic [31:0] rem_q;      // partial remainder
    logic [31:0] dvd_q;      // dividend magnitude, quotient bits shift in at LSB
    logic [31:0] dvs_q;      // divisor magnitude
    logic        neg_quo_q, neg_rem_q, fast_q;

    logic        accept, finish;
    logic        a_neg, b_neg, div0, ovf;
    logic [31:0] a_mag, b_mag;

    // Start is only honoured outside CALC, so DONE can accept back-to-back.
    assign accept = start && (state_q != CALC);
    assign finish = (state_q == CALC) && (fast_q || (cnt_q == 6'd32));

    // Operand classification and magnitudes; unsigned operands are never negated.
    assign a_neg = is_signed & a[31];
    assign b_neg = is_signed & b[31];
    assign a_mag = a_neg ? (~a + 32'd1) : a;
    assign b_mag = b_neg ? (~b + 32'd1) : b;
    assign div0  = (b == 32'd0);
    assign ovf   = is_signed && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    // Trial subtraction: {rem, next dividend bit} - divisor over 33 bits,
    // built as a ripple-carry chain with inverted divisor and carry-in of 1.
    // Carry out set means no borrow, i.e. the step result is kept. Sum bit 32
    // is never needed because a kept result always fits in 32 bits.
    logic [32:0] trial_x, trial_y;
    logic [33:0] carry;
    logic [31:0] diff;
    logic        keep;

    assign trial_x  = {rem_q, dvd_q[31]};
    assign trial_y  = ~{1'b0, dvs_q};
    assign carry[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < 33; gi++) begin : g_rca
            assign carry[gi+1] = (trial_x[gi] & trial_y[gi]) |
                                 (trial_x[gi] & carry[gi])   |
                                 (trial_y[gi] & carry[gi]);
            if (gi < 32) begin : g_sum
                assign diff[gi] = trial_x[gi] ^ trial_y[gi] ^ carry[gi];
            end
        end
    endgenerate

    assign keep = carry[33];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = CALC;
            CALC:    if (finish) state_d = DONE;
            DONE:    state_d = accept ? CALC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        busy = (state_q == CALC);
        done = (state_q == DONE);
    end

    // Working registers: load on accept, one restoring step per CALC cycle.
    // Fast-path cases preload the final magnitudes with no sign correction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            fast_q    <= 1'b0;
        end else if (accept) begin
            cnt_q  <= '0;
            dvs_q  <= b_mag;
            fast_q <= div0 | ovf;
            if (div0) begin
                dvd_q     <= 32'hFFFF_FFFF;
                rem_q     <= a;
                neg_quo_q <= 1'b0;
                neg_rem_q <= 1'b0;
            end else if (ovf) begin
                dvd_q     <= 32'h8000_0000;
                rem_q     <= '0;
                neg_quo_q <= 1'b0;
                neg_rem_q <= 1'b0;
            end else begin
                dvd_q     <= a_mag;
                rem_q     <= '0;
                neg_quo_q <= a_neg ^ b_neg;
                neg_rem_q <= a_neg;
            end
        end else if ((state_q == CALC) && !finish) begin
            rem_q <= keep ? diff : trial_x[31:0];
            dvd_q <= {dvd_q[30:0], keep};
            cnt_q <= cnt_q + 6'd1;
        end
    end

    // Result registers: updated only on the finishing edge, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient  <= '0;
            remainder <= '0;
        end else if (finish) begin
            quotient  <= neg_quo_q ? (~dvd_q + 32'd1) : dvd_q;
            remainder <= neg_rem_q ? (~rem_q + 32'd1) : rem_q;
        end
    end

endmodule
